wb_cache_ctrl: RTL and testbench
================================

Name: wb_cache_ctrl

Overview:
- Parametrised, direct-mapped, write-back, write-allocate cache controller. Successor to the fixed 32-bit-address / 256-bit-line cache type definitions.
- Sits between the CPU request/result interface and the memory request/response interface.
- Owns the tag/valid/dirty and data arrays.
- Line geometry and index depth are generic, and it runs a full hit/miss/write-back/allocate FSM.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, CPU data word width (multiple of 8).
- LINE_WORDS, 8, words per line (power of 2); line width LINE_W = WORD_W*LINE_WORDS.
- INDEX_BITS, 10, set-index width; depth 2**INDEX_BITS.
- Derived constants:
  - OFF_BITS = log2(LINE_W/8).
  - WSEL_BITS = log2(LINE_WORDS).
  - TAG_BITS = ADDR_W-INDEX_BITS-OFF_BITS.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req_addr  in  ADDR_W  request byte address
- cpu_req_data  in  WORD_W  write data
- cpu_req_rw  in  1  0=read, 1=write
- cpu_req_valid  in  1  request valid
- cpu_res_data  out  WORD_W  read data
- cpu_res_ready  out  1  one-cycle completion pulse
- mem_req_addr  out  ADDR_W  line-aligned byte address
- mem_req_data  out  LINE_W  write-back line
- mem_req_rw  out  1  0=read, 1=write
- mem_req_valid  out  1  memory request valid
- mem_res_data  in  LINE_W  fill line
- mem_res_ready  in  1  memory done (read data valid / write accepted)

Behaviour:
- Address split:
  - word select = addr[OFF_BITS-1 : OFF_BITS-WSEL_BITS]
  - index = addr[OFF_BITS+INDEX_BITS-1 : OFF_BITS]
  - tag = addr[ADDR_W-1 : OFF_BITS+INDEX_BITS]
  - Byte bits below the word select are ignored.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE:
  - cpu_req_valid=1 at an edge captures addr/data/rw into request registers; next state COMPARE.
  - The CPU must not issue another request until it sees cpu_res_ready.
- COMPARE: hit = valid[idx] & tag match.
  - Read hit: cpu_res_ready=1 and cpu_res_data = selected word in this cycle; next state IDLE.
  - Write hit: word written, dirty set, cpu_res_ready=1; next state IDLE.
  - Miss with line invalid or clean: next state ALLOCATE.
  - Miss with line valid and dirty: next state WRITE_BACK.
- WRITE_BACK:
  - Drives mem_req_valid=1, rw=1, addr={old_tag, idx, 0}, data = stored line.
  - On an edge with mem_res_ready=1, next state ALLOCATE.
- ALLOCATE:
  - Drives mem_req_valid=1, rw=0, addr={req_tag, idx, 0}.
  - On mem_res_ready=1: line ← mem_res_data, tag ← req_tag, valid=1, dirty=0; next state COMPARE, which re-evaluates as a hit.
- Hit latency: accept edge, then cpu_res_ready high in the following cycle.
- Memory handshake:
  - mem_req_* are registered outputs that stay stable while valid.
  - mem_req_valid falls the cycle after mem_res_ready is sampled.
  - mem_res_ready outside WRITE_BACK/ALLOCATE is ignored.
- Reset values:
  - cpu_res_ready=0, cpu_res_data=0.
  - mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0.
  - state IDLE; all valid and dirty bits cleared.
  - Data array is not reset.
- Reset mid-operation: abandons the request; no cpu_res_ready. Dirty lines are discarded without write-back.
- cpu_req_valid outside IDLE is ignored.

Optional Feature:
- WB_CACHE_PERF_COUNTERS_EN defined:
  - Adds outputs hit_count, miss_count, wb_count (32 bits each).
  - Each is incremented once per request at its first COMPARE cycle (hit/miss) or WRITE_BACK completion (wb).
  - Counters wrap on overflow and are cleared by rst.
- Undefined: the ports and logic do not exist.

Decomposition:
- Shared package wb_cache_pkg contains:
  - State enum.
  - Parametrised tag struct {valid, dirty, tag}.
  - Field-extraction functions.
  - CPU/memory request/result structs.
- Sub-module wb_cache_store:
  - Holds the tag and data arrays.
  - Asynchronous read, synchronous write.
  - Supports full-line fill and single-word write.
  - Reset clears valid/dirty.

Test Plan (defaults; 0x00001234 → idx 0x091, word 5):
- Read 0x00001234 after reset → mem read addr 0x00001220; return line with word5=0xDEADBEEF → cpu_res_data 0xDEADBEEF, no write-back.
- Repeat read 0x00001234 → cpu_res_ready exactly 1 cycle after accept, mem_req_valid stays 0.
- Write 0x00001234 data 0xCAFEF00D, then read it → hit both, returns 0xCAFEF00D, no memory traffic.
- Read 0x00009234 (same idx, tag 1) → mem write addr 0x00001220 with word5=0xCAFEF00D, then mem read addr 0x00009220, then data returned.
- Assert rst in ALLOCATE with mem_req_valid=1 → next cycle mem_req_valid=0, no cpu_res_ready; a subsequent read of 0x00001234 misses.
- With WB_CACHE_PERF_COUNTERS_EN, running scenarios 1–4 in sequence → hit_count=3, miss_count=2, wb_count=1.

Source files
------------

// File: rtl/wb_cache_pkg.sv
// wb_cache_pkg: shared FSM state, default-geometry bus structs and
// address field helpers for the write-back cache controller.
package wb_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_COMPARE    = 2'd1,
        ST_WRITE_BACK = 2'd2,
        ST_ALLOCATE   = 2'd3
    } cache_state_e;

    // Default geometry: 32-bit byte address, 8 x 32-bit words per line, 1024 sets.
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_INDEX_BITS = 10;
    localparam int DEF_LINE_W     = DEF_WORD_W * DEF_LINE_WORDS;
    localparam int DEF_OFF_BITS   = $clog2(DEF_LINE_W / 8);
    localparam int DEF_TAG_BITS   = DEF_ADDR_W - DEF_INDEX_BITS - DEF_OFF_BITS;

    // Default-geometry views of the tag entry and the CPU / memory channels.
    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [DEF_TAG_BITS-1:0] tag;
    } def_tag_entry_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_WORD_W-1:0] data;
        logic                  rw;
        logic                  valid;
    } def_cpu_req_t;

    typedef struct packed {
        logic [DEF_WORD_W-1:0] data;
        logic                  ready;
    } def_cpu_res_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LINE_W-1:0] data;
        logic                  rw;
        logic                  valid;
    } def_mem_req_t;

    typedef struct packed {
        logic [DEF_LINE_W-1:0] data;
        logic                  ready;
    } def_mem_res_t;

    // Generic field extraction; callers size-cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_wsel(input logic [63:0] addr, input int off_bits, input int wsel_bits);
        return addr_field(addr, off_bits - wsel_bits, wsel_bits);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off_bits, input int index_bits);
        return addr_field(addr, off_bits, index_bits);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_bits, input int index_bits,
                                             input int addr_w);
        return addr_field(addr, off_bits + index_bits, addr_w - off_bits - index_bits);
    endfunction

endpackage

// File: rtl/wb_cache_store.sv
// wb_cache_store: tag, valid/dirty and data arrays. Asynchronous read,
// synchronous write; a fill loads a whole clean line, a word write marks it dirty.
module wb_cache_store
    import wb_cache_pkg::*;
#(
    parameter int TAG_BITS   = 17,
    parameter int INDEX_BITS = 10,
    parameter int WORD_W     = 32,
    parameter int LINE_W     = 256,
    parameter int WSEL_BITS  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_BITS-1:0]   tag_o,
    output logic [LINE_W-1:0]     line_o,
    input  logic                  fill_en_i,
    input  logic [TAG_BITS-1:0]   fill_tag_i,
    input  logic [LINE_W-1:0]     fill_line_i,
    input  logic                  word_en_i,
    input  logic [WSEL_BITS-1:0]  wsel_i,
    input  logic [WORD_W-1:0]     word_i
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [DEPTH];
    logic [LINE_W-1:0]   data_q [DEPTH];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // Line state bits: cleared by reset, fill leaves the line clean, word write dirties it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their contents.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_en_i) begin
            data_q[idx_i][wsel_i * WORD_W +: WORD_W] <= word_i;
        end
    end

endmodule

// File: rtl/wb_cache_ctrl.sv
// wb_cache_ctrl: direct-mapped, write-back, write-allocate cache controller
// between a single-outstanding CPU port and a line-wide memory port.
// Optional feature macro: WB_CACHE_PERF_COUNTERS_EN adds hit/miss/write-back counters.
//
// state          | meaning
// ST_IDLE        | waiting for a CPU request
// ST_COMPARE     | tag lookup; a hit completes, a miss picks write-back or allocate
// ST_WRITE_BACK  | dirty victim line offered to memory as a write
// ST_ALLOCATE    | requested line fetched from memory, then re-compared
module wb_cache_ctrl
    import wb_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int INDEX_BITS = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_W-1:0]            cpu_req_addr_i,
    input  logic [WORD_W-1:0]            cpu_req_data_i,
    input  logic                         cpu_req_rw_i,
    input  logic                         cpu_req_valid_i,
    output logic [WORD_W-1:0]            cpu_res_data_o,
    output logic                         cpu_res_ready_o,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [WORD_W*LINE_WORDS-1:0] mem_req_data_o,
    output logic                         mem_req_rw_o,
    output logic                         mem_req_valid_o,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_res_data_i,
    input  logic                         mem_res_ready_i
`ifdef WB_CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  hit_count_o,
    output logic [31:0]                  miss_count_o,
    output logic [31:0]                  wb_count_o
`endif
);

    localparam int LINE_W    = WORD_W * LINE_WORDS;
    localparam int OFF_BITS  = $clog2(LINE_W / 8);
    localparam int WSEL_BITS = $clog2(LINE_WORDS);
    localparam int TAG_BITS  = ADDR_W - INDEX_BITS - OFF_BITS;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
    } line_tag_t;

    cache_state_e state_q, state_d;

    logic [TAG_BITS-1:0]   req_tag_q;
    logic [INDEX_BITS-1:0] req_idx_q;
    logic [WSEL_BITS-1:0]  req_wsel_q;
    logic [WORD_W-1:0]     req_data_q;
    logic                  req_rw_q;

    logic                  rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [LINE_W-1:0]     rd_line;
    line_tag_t             rd_entry;
    logic [WORD_W-1:0]     rd_word;
    logic                  hit;
    logic                  accept;
    logic                  mem_done;
    logic                  fill_en, word_wr_en;

    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  mem_req_rw_q, mem_req_rw_d;
    logic [ADDR_W-1:0]     mem_req_addr_q, mem_req_addr_d;
    logic [LINE_W-1:0]     mem_req_data_q, mem_req_data_d;

    wb_cache_store #(
        .TAG_BITS   (TAG_BITS),
        .INDEX_BITS (INDEX_BITS),
        .WORD_W     (WORD_W),
        .LINE_W     (LINE_W),
        .WSEL_BITS  (WSEL_BITS)
    ) u_store (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx_q),
        .valid_o     (rd_valid),
        .dirty_o     (rd_dirty),
        .tag_o       (rd_tag),
        .line_o      (rd_line),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag_q),
        .fill_line_i (mem_res_data_i),
        .word_en_i   (word_wr_en),
        .wsel_i      (req_wsel_q),
        .word_i      (req_data_q)
    );

    assign rd_entry = {rd_valid, rd_dirty, rd_tag};
    assign rd_word  = rd_line[req_wsel_q * WORD_W +: WORD_W];
    assign hit      = rd_entry.valid && (rd_entry.tag == req_tag_q);
    assign accept   = (state_q == ST_IDLE) && cpu_req_valid_i;
    // A handshake only completes while our request is actually up, so the
    // idle gap cycle between write-back and allocate cannot be acknowledged.
    assign mem_done = ((state_q == ST_WRITE_BACK) || (state_q == ST_ALLOCATE)) &&
                      mem_req_valid_q && mem_res_ready_i;

    // Request capture; only the address fields are kept, byte bits are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            req_wsel_q <= '0;
            req_data_q <= '0;
            req_rw_q   <= 1'b0;
        end else if (accept) begin
            req_tag_q  <= TAG_BITS'(addr_tag(64'(cpu_req_addr_i), OFF_BITS, INDEX_BITS, ADDR_W));
            req_idx_q  <= INDEX_BITS'(addr_index(64'(cpu_req_addr_i), OFF_BITS, INDEX_BITS));
            req_wsel_q <= WSEL_BITS'(addr_wsel(64'(cpu_req_addr_i), OFF_BITS, WSEL_BITS));
            req_data_q <= cpu_req_data_i;
            req_rw_q   <= cpu_req_rw_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid_i) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (hit)                              state_d = ST_IDLE;
                else if (rd_entry.valid && rd_entry.dirty) state_d = ST_WRITE_BACK;
                else                                  state_d = ST_ALLOCATE;
            end
            ST_WRITE_BACK: begin
                if (mem_done) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                if (mem_done) state_d = ST_COMPARE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: CPU result, array write strobes and next memory request.
    always_comb begin
        cpu_res_ready_o = 1'b0;
        cpu_res_data_o  = '0;
        fill_en         = 1'b0;
        word_wr_en      = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_req_rw_d    = mem_req_rw_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_data_d  = mem_req_data_q;

        if (state_q == ST_COMPARE && hit) begin
            cpu_res_ready_o = 1'b1;
            word_wr_en      = req_rw_q;
            if (!req_rw_q) cpu_res_data_o = rd_word;
        end
        if (state_q == ST_ALLOCATE && mem_done) fill_en = 1'b1;

        // Request fields are computed from the next state so they are already
        // settled when valid rises; the completing edge forces one idle cycle.
        if (state_d == ST_WRITE_BACK) begin
            mem_req_valid_d = !mem_done;
            mem_req_rw_d    = 1'b1;
            mem_req_addr_d  = {rd_entry.tag, req_idx_q, {OFF_BITS{1'b0}}};
            mem_req_data_d  = rd_line;
        end else if (state_d == ST_ALLOCATE) begin
            mem_req_valid_d = !mem_done;
            mem_req_rw_d    = 1'b0;
            mem_req_addr_d  = {req_tag_q, req_idx_q, {OFF_BITS{1'b0}}};
        end
    end

    // Registered memory request outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_valid_q <= 1'b0;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
        end else begin
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_rw_q    <= mem_req_rw_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_data_q  <= mem_req_data_d;
        end
    end

    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_rw_o    = mem_req_rw_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    assign mem_req_data_o  = mem_req_data_q;

`ifdef WB_CACHE_PERF_COUNTERS_EN
    logic        first_cmp_q;
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    // Hit/miss is classified only on the first compare of a request; the
    // re-compare after allocate is not counted again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_cmp_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            if (accept)                       first_cmp_q <= 1'b1;
            else if (state_q == ST_COMPARE)   first_cmp_q <= 1'b0;
            if (state_q == ST_COMPARE && first_cmp_q) begin
                if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
                else     miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (state_q == ST_WRITE_BACK && mem_done) wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign wb_count_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// tb_wb_cache_ctrl: directed test-plan scenarios followed by random traffic,
// checked against a behavioural direct-mapped cache and memory model.
module tb_wb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic         cpu_req_rw;
    logic         cpu_req_valid;
    logic [31:0]  cpu_res_data;
    logic         cpu_res_ready;
    logic [31:0]  mem_req_addr;
    logic [255:0] mem_req_data;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic [255:0] mem_res_data;
    logic         mem_res_ready;
`ifdef WB_CACHE_PERF_COUNTERS_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    wb_cache_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cpu_req_addr_i  (cpu_req_addr),
        .cpu_req_data_i  (cpu_req_data),
        .cpu_req_rw_i    (cpu_req_rw),
        .cpu_req_valid_i (cpu_req_valid),
        .cpu_res_data_o  (cpu_res_data),
        .cpu_res_ready_o (cpu_res_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_data_o  (mem_req_data),
        .mem_req_rw_o    (mem_req_rw),
        .mem_req_valid_o (mem_req_valid),
        .mem_res_data_i  (mem_res_data),
        .mem_res_ready_i (mem_res_ready)
`ifdef WB_CACHE_PERF_COUNTERS_EN
        ,
        .hit_count_o     (hit_count),
        .miss_count_o    (miss_count),
        .wb_count_o      (wb_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_op_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-set cache contents plus a sparse backing memory.
    logic         ref_valid [1024];
    logic         ref_dirty [1024];
    logic [16:0]  ref_tag   [1024];
    logic [255:0] ref_line  [1024];
    logic [255:0] mem_model [int unsigned];
    mem_op_t      exp_ops[$];
    int           model_hit = 0, model_miss = 0, model_wb = 0;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data;
    logic [31:0]  last_rd_word;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        model_hit = 0; model_miss = 0; model_wb = 0;
    endtask

    // One CPU request: predict with the model, drive it, act as memory, check results.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata, input logic rw,
                           input string tag);
        logic [9:0]  idx;
        logic [16:0] t;
        logic [2:0]  w;
        logic [31:0] la, ola;
        logic        exp_hit;
        logic [31:0] exp_word;
        mem_op_t     op;
        int          cycles, wait_n, n_ops, lat;
        bit          got, in_req, was_resp;

        idx = addr[14:5];
        t   = addr[31:15];
        w   = addr[4:2];
        la  = {addr[31:5], 5'b0};
        exp_ops.delete();
        exp_hit = ref_valid[idx] && (ref_tag[idx] == t);
        if (exp_hit) begin
            model_hit++;
        end else begin
            model_miss++;
            if (ref_valid[idx] && ref_dirty[idx]) begin
                ola = {ref_tag[idx], idx, 5'b0};
                op  = '{1'b1, ola, ref_line[idx]};
                exp_ops.push_back(op);
                mem_model[ola] = ref_line[idx];
                model_wb++;
            end
            if (!mem_model.exists(la)) mem_model[la] = rand_line();
            op = '{1'b0, la, 256'b0};
            exp_ops.push_back(op);
            ref_line[idx]  = mem_model[la];
            ref_tag[idx]   = t;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        exp_word = ref_line[idx][w*32 +: 32];
        if (rw) begin
            ref_line[idx][w*32 +: 32] = wdata;
            ref_dirty[idx] = 1'b1;
        end

        @(negedge clk);
        cpu_req_addr  = addr;
        cpu_req_data  = wdata;
        cpu_req_rw    = rw;
        cpu_req_valid = 1'b1;
        mem_res_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cpu_req_valid = 1'($urandom_range(0, 1));
        cpu_req_addr  = $urandom;
        cpu_req_rw    = 1'($urandom_range(0, 1));
        mem_res_ready = 1'($urandom_range(0, 1));

        cycles = 0; got = 0; in_req = 0; was_resp = 0; n_ops = 0; lat = -1; wait_n = 0;
        last_rd_word = '0;
        while (!got && cycles < 100) begin
            if (was_resp) begin
                check({tag, "_memvalid_drop"}, 256'(mem_req_valid), 256'(1'b0));
                was_resp = 0;
            end
            if (cpu_res_ready) begin
                got = 1;
                lat = cycles;
                last_rd_word = cpu_res_data;
            end else if (mem_req_valid) begin
                if (!in_req) begin
                    in_req = 1;
                    wait_n = $urandom_range(0, 2);
                    if (n_ops < exp_ops.size()) begin
                        op = exp_ops[n_ops];
                        check({tag, "_mem_rw"}, 256'(mem_req_rw), 256'(op.rw));
                        check({tag, "_mem_addr"}, 256'(mem_req_addr), 256'(op.addr));
                        if (op.rw) check({tag, "_mem_wdata"}, mem_req_data, op.data);
                    end
                    if (mem_req_rw) begin
                        last_wb_addr = mem_req_addr;
                        last_wb_data = mem_req_data;
                    end
                    n_ops++;
                end
                if (wait_n == 0) begin
                    mem_res_ready = 1'b1;
                    mem_res_data  = mem_model.exists(mem_req_addr) ? mem_model[mem_req_addr] : 256'b0;
                    in_req   = 0;
                    was_resp = 1;
                end else begin
                    wait_n--;
                end
            end
            @(negedge clk);
            mem_res_ready = 1'b0;
            if (!got) begin
                cpu_req_valid = 1'($urandom_range(0, 1));
                cpu_req_addr  = $urandom;
            end
            cycles++;
        end

        check({tag, "_done"}, 256'(got), 256'(1'b1));
        check({tag, "_mem_ops"}, 256'(n_ops), 256'(exp_ops.size()));
        if (exp_hit) check({tag, "_hit_latency"}, 256'(lat), 256'(0));
        if (!rw) check({tag, "_rdata"}, 256'(last_rd_word), 256'(exp_word));

        // The loop left us one negedge into the post-response IDLE cycle.
        cpu_req_valid = 1'b0;
        check({tag, "_ready_pulse"}, 256'(cpu_res_ready), 256'(1'b0));
        check({tag, "_mem_idle"}, 256'(mem_req_valid), 256'(1'b0));
    endtask

    logic [255:0] init_line;
    logic [31:0]  r_addr;
    logic [9:0]   r_idx;
    int           r_sel;
    bit           seen;

    initial begin
        rst           = 1'b1;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        cpu_req_rw    = 1'b0;
        cpu_req_valid = 1'b0;
        mem_res_data  = '0;
        mem_res_ready = 1'b0;
        clear_model();

        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 256'(cpu_res_ready), 256'(1'b0));
        check("rst_cpu_data",  256'(cpu_res_data),  256'(0));
        check("rst_mem_valid", 256'(mem_req_valid), 256'(1'b0));
        check("rst_mem_rw",    256'(mem_req_rw),    256'(1'b0));
        check("rst_mem_addr",  256'(mem_req_addr),  256'(0));
        check("rst_mem_data",  mem_req_data,        256'(0));
        rst = 1'b0;

        // Scenario 1: cold read miss, line returned with word 5 = DEADBEEF.
        init_line = rand_line();
        init_line[5*32 +: 32] = 32'hDEADBEEF;
        mem_model[32'h00001220] = init_line;
        run_req(32'h00001234, 32'h0, 1'b0, "s1_read_miss");
        check("s1_word", 256'(last_rd_word), 256'(32'hDEADBEEF));

        // Scenario 2: repeat read hits with no memory traffic.
        run_req(32'h00001234, 32'h0, 1'b0, "s2_read_hit");

        // Scenario 3: write hit then read hit.
        run_req(32'h00001234, 32'hCAFEF00D, 1'b1, "s3_write_hit");
        run_req(32'h00001234, 32'h0, 1'b0, "s3_read_hit");
        check("s3_word", 256'(last_rd_word), 256'(32'hCAFEF00D));

        // Scenario 4: conflicting tag evicts the dirty line.
        run_req(32'h00009234, 32'h0, 1'b0, "s4_evict");
        check("s4_wb_addr", 256'(last_wb_addr), 256'(32'h00001220));
        check("s4_wb_word5", 256'(last_wb_data[5*32 +: 32]), 256'(32'hCAFEF00D));

`ifdef WB_CACHE_PERF_COUNTERS_EN
        check("perf_hit_s1_4",  256'(hit_count),  256'(3));
        check("perf_miss_s1_4", 256'(miss_count), 256'(2));
        check("perf_wb_s1_4",   256'(wb_count),   256'(1));
`endif

        // Scenario 5: reset while an allocate request is outstanding.
        @(negedge clk);
        cpu_req_addr  = 32'h00011234;
        cpu_req_rw    = 1'b0;
        cpu_req_valid = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (mem_req_valid) seen = 1;
            else @(negedge clk);
        end
        check("s5_alloc_seen", 256'(seen), 256'(1'b1));
        check("s5_alloc_rw",   256'(mem_req_rw), 256'(1'b0));
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_valid", 256'(mem_req_valid), 256'(1'b0));
        check("s5_rst_ready", 256'(cpu_res_ready), 256'(1'b0));
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("s5_post_ready", 256'(cpu_res_ready), 256'(1'b0));
        check("s5_post_valid", 256'(mem_req_valid), 256'(1'b0));
        run_req(32'h00001234, 32'h0, 1'b0, "s5_read_after_rst");
        check("s5_word", 256'(last_rd_word), 256'(32'hCAFEF00D));

        // Random traffic concentrated on a few sets to force conflicts and evictions.
        for (int n = 0; n < 80; n++) begin
            r_sel = $urandom_range(0, 2);
            r_idx = (r_sel == 0) ? 10'h091 : (r_sel == 1) ? 10'h092 : 10'($urandom_range(0, 1023));
            r_addr = {15'($urandom_range(0, 3)), r_idx, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            run_req(r_addr, $urandom, 1'($urandom_range(0, 1)), "rnd");
        end

`ifdef WB_CACHE_PERF_COUNTERS_EN
        check("perf_hit_end",  256'(hit_count),  256'(model_hit));
        check("perf_miss_end", 256'(miss_count), 256'(model_miss));
        check("perf_wb_end",   256'(wb_count),   256'(model_wb));
`else
        $display("[TB] model counts: %0d hits, %0d misses, %0d write-backs", model_hit, model_miss, model_wb);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
